// File: rtl/eka_pkg.sv
// Shared types and constants for the instruction fetch stage.
package eka_pkg;

  localparam int FETCH_ADDR_WIDTH  = 32;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int FETCH_PC_WIDTH    = FETCH_ADDR_WIDTH - 2;

  localparam int FETCH_Q_DEPTH = 2;
  localparam int Q_PTR_W       = $clog2(FETCH_Q_DEPTH);
  localparam int Q_CNT_W       = $clog2(FETCH_Q_DEPTH + 1);

  // One fetched instruction together with the word PC it was read from.
  typedef struct packed {
    logic [FETCH_PC_WIDTH-1:0]    pc_word;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Queue pointer increment with wrap at the queue depth.
  function automatic logic [Q_PTR_W-1:0] q_ptr_inc(input logic [Q_PTR_W-1:0] ptr);
    return (ptr == Q_PTR_W'(FETCH_Q_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode valid/ready channel.
interface instr_fetch_if
  import eka_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
);

  logic                   if_valid;
  logic                   if_ready;
  logic [ADDR_WIDTH-1:0]  if_pc;
  logic [INSTR_WIDTH-1:0] if_instr;

  modport master (output if_valid, if_pc, if_instr, input if_ready);
  modport slave  (input if_valid, if_pc, if_instr, output if_ready);

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries with synchronous flush.
module fetch_queue
  import eka_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enq,
  input  logic               deq,
  input  logic               flush,
  input  fetch_entry_t       enq_data,
  output logic [Q_CNT_W-1:0] count,
  output fetch_entry_t       head
);

  fetch_entry_t        mem [FETCH_Q_DEPTH];
  logic [Q_PTR_W-1:0]  wr_ptr;
  logic [Q_PTR_W-1:0]  rd_ptr;

  // Pointer and occupancy bookkeeping; a flush empties the queue like a reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= q_ptr_inc(wr_ptr);
      if (deq) rd_ptr <= q_ptr_inc(rd_ptr);
      count <= count + Q_CNT_W'(enq) - Q_CNT_W'(deq);
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // contents are never observed and the array can map to plain flops/RAM.
    if (enq && !flush) mem[wr_ptr] <= enq_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives imem from the PC register, pairs responses with their
// PC, buffers them towards decode and steers redirects back into the PC register.
module instr_fetch
  import eka_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-3:0]  PC,
  output logic [ADDR_WIDTH-3:0]  pc_other_ip,
  output logic                   pc_other_ip_sel,
  output logic [ADDR_WIDTH-3:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   ex_redirect,
  input  logic [ADDR_WIDTH-3:0]  ex_target,
  instr_fetch_if.master          dec
);

  // The queue entry type is fixed by the package widths.
  if (ADDR_WIDTH != FETCH_ADDR_WIDTH || INSTR_WIDTH != FETCH_INSTR_WIDTH) begin : g_width_check
    $error("instr_fetch widths must match eka_pkg fetch_entry_t");
  end

  logic                  req_valid_q;
  logic                  kill_q;
  logic [ADDR_WIDTH-3:0] req_pc_q;

  logic [Q_CNT_W-1:0]    q_count;
  fetch_entry_t          q_head;
  fetch_entry_t          resp_entry;
  logic                  q_enq;
  logic                  q_deq;
  logic                  has_space;
  logic                  resp_live;
  logic                  replay;

  assign imem_addr  = PC;
  assign resp_entry = '{pc_word: req_pc_q, instr: imem_rdata};

  // Track the outstanding imem request and whether its response is wrong-path.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      kill_q      <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      req_valid_q <= 1'b1;
      kill_q      <= pc_other_ip_sel;
      req_pc_q    <= PC;
    end
  end

  // Response steering, decode handshake and redirect mux (execute wins over replay).
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can
    // leave one unassigned and infer a latch.
    dec.if_valid    = 1'b0;
    q_deq           = 1'b0;
    has_space       = 1'b0;
    resp_live       = 1'b0;
    q_enq           = 1'b0;
    replay          = 1'b0;
    pc_other_ip_sel = 1'b0;
    pc_other_ip     = '0;

    dec.if_valid = (q_count != '0) && !ex_redirect;
    q_deq        = dec.if_valid && dec.if_ready;
    has_space    = (q_count < Q_CNT_W'(FETCH_Q_DEPTH)) || q_deq;
    resp_live    = req_valid_q && !kill_q && !ex_redirect;
    q_enq        = resp_live && has_space;
    replay       = resp_live && !has_space;

    if (ex_redirect) begin
      pc_other_ip_sel = 1'b1;
      pc_other_ip     = ex_target;
    end else if (replay) begin
      pc_other_ip_sel = 1'b1;
      pc_other_ip     = req_pc_q;
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq      (q_enq),
    .deq      (q_deq),
    .flush    (ex_redirect),
    .enq_data (resp_entry),
    .count    (q_count),
    .head     (q_head)
  );

  assign dec.if_pc    = {q_head.pc_word, 2'b00};
  assign dec.if_instr = q_head.instr;

endmodule
